// File: rtl/upcounter_datapath.sv
// Counting stage of the SPI up-counter: fixed-rate prescaler, modulo counter and
// a latest-wins transmit holding register feeding the SPI master.
module upcounter_datapath #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = 9999,
    parameter int CNT_W     = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             runstop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic [15:0]      tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int P_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [P_W-1:0]   P_LAST  = P_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    if (DIV < 2) begin : g_bad_div
        $error("upcounter_datapath: CLK_HZ/TICK_HZ must be at least 2");
    end
    if ((64'd1 << CNT_W) <= 64'(MAX_COUNT)) begin : g_bad_cnt_w
        $error("upcounter_datapath: CNT_W too narrow for MAX_COUNT");
    end

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? '0 : c + 1'b1;
    endfunction

    function automatic logic [15:0] to_tx(input logic [CNT_W-1:0] c);
        return 16'(c);
    endfunction

    logic [P_W-1:0]   r_p;
    logic [CNT_W-1:0] r_count;
    logic [15:0]      r_tx_data;
    logic             r_tx_valid;

    logic             w_tick;
    logic [P_W-1:0]   w_p_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_update;

    always_comb begin
        w_tick = runstop && !clear && (r_p == P_LAST);
    end

    // Holding the prescaler while stopped keeps the partial period across a pause.
    always_comb begin
        w_p_nxt = r_p;
        if (clear) begin
            w_p_nxt = '0;
        end else if (runstop) begin
            w_p_nxt = (r_p == P_LAST) ? '0 : r_p + 1'b1;
        end
    end

    always_comb begin
        w_cnt_nxt = r_count;
        if (clear) begin
            w_cnt_nxt = '0;
        end else if (w_tick) begin
            w_cnt_nxt = wrap_inc(r_count);
        end
    end

    // Any change of value is an update; clearing an already-zero count is not.
    always_comb begin
        w_update = (w_cnt_nxt != r_count);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p     <= '0;
            r_count <= '0;
        end else begin
            r_p     <= w_p_nxt;
            r_count <= w_cnt_nxt;
        end
    end

    // A new value always overwrites the pending one, so the newest count is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_update) begin
            r_tx_data  <= to_tx(w_cnt_nxt);
            r_tx_valid <= 1'b1;
        end else if (r_tx_valid && tx_ready) begin
            r_tx_valid <= 1'b0;
        end
    end

    assign count    = r_count;
    assign tick     = w_tick;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_upcounter_datapath.sv
// Scoreboard bench for upcounter_datapath: count is derived from the number of
// running cycles since reset/clear; transfers are queued and checked by a monitor.
module tb_upcounter_datapath;

    localparam int CLK_HZ    = 10;
    localparam int TICK_HZ   = 1;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int MAX_COUNT = 9;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             runstop;
    logic             clear;
    logic [CNT_W-1:0] count;
    logic             tick;
    logic [15:0]      tx_data;
    logic             tx_valid;
    logic             tx_ready;

    upcounter_datapath #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_COUNT(MAX_COUNT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .runstop(runstop), .clear(clear),
        .count(count), .tick(tick), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;

    // Reference state: running cycles since last reset/clear, and the pending transmit value.
    int run_cycles;
    int m_count;
    bit m_valid;
    int m_pending;

    int exp_count;
    bit exp_tick;
    bit exp_valid;
    int exp_data;
    int exp_x;
    bit mon_en = 1'b0;
    int xfer_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        run_cycles = 0;
        m_count    = 0;
        m_valid    = 1'b0;
        m_pending  = 0;
        exp_count  = 0;
        exp_tick   = 1'b0;
        exp_valid  = 1'b0;
        exp_data   = 0;
        xfer_q.delete();
    endtask

    // Drive one cycle of inputs and advance the reference across the following edge.
    task automatic step(input bit rs, input bit cl, input bit rd);
        int nxt;
        @(posedge clk);
        #2;
        runstop  = rs;
        clear    = cl;
        tx_ready = rd;
        exp_count = m_count;
        exp_valid = m_valid;
        exp_data  = m_pending;
        exp_tick  = rs && !cl && ((run_cycles % DIV) == DIV - 1);
        if (m_valid && rd) xfer_q.push_back(m_pending);
        if (cl) run_cycles = 0;
        else if (rs) run_cycles++;
        nxt = (run_cycles / DIV) % (MAX_COUNT + 1);
        if (nxt != m_count) begin
            m_pending = nxt;
            m_valid   = 1'b1;
        end else if (m_valid && rd) begin
            m_valid = 1'b0;
        end
        m_count = nxt;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        mon_en   = 1'b0;
        reset    = 1'b1;
        runstop  = 1'b0;
        clear    = 1'b0;
        tx_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_async_count", 32'(count), 0);
        chk("rst_async_valid", 32'(tx_valid), 0);
        chk("rst_async_data", 32'(tx_data), 0);
        repeat (2) @(posedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", 32'(count), 32'(exp_count));
            chk("tick", 32'(tick), 32'(exp_tick));
            chk("tx_valid", 32'(tx_valid), 32'(exp_valid));
            if (exp_valid) chk("tx_data", 32'(tx_data), 32'(exp_data));
            if (tx_valid && tx_ready) begin
                if (xfer_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL xfer_unexpected data=%0d expected=none at %0t", tx_data, $time);
                end else begin
                    exp_x = xfer_q.pop_front();
                    chk("xfer_data", 32'(tx_data), 32'(exp_x));
                    n_xfer++;
                end
            end
            chk("xfer_backlog", 32'(xfer_q.size()), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog bench did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        runstop  = 1'b0;
        clear    = 1'b0;
        tx_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_count", 32'(count), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_tx_data", 32'(tx_data), 0);
        chk("reset_tx_valid", 32'(tx_valid), 0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Free run with the SPI side always ready.
        repeat (35) step(1'b1, 1'b0, 1'b1);

        // Pause mid-period and resume.
        do_reset();
        repeat (25) step(1'b1, 1'b0, 1'b1);
        repeat (30) step(1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b0, 1'b1);

        // Back-pressure across several ticks, then release.
        do_reset();
        repeat (35) step(1'b1, 1'b0, 1'b0);
        repeat (5)  step(1'b1, 1'b0, 1'b1);

        // Run through the wrap at MAX_COUNT.
        repeat (120) step(1'b1, 1'b0, 1'($urandom_range(0, 1)));

        // Clear from a nonzero count while running.
        for (int i = 0; i < 300 && m_count != 7; i++) step(1'b1, 1'b0, 1'b1);
        chk("reached_seven", 32'(m_count), 7);
        repeat (4)  step(1'b1, 1'b1, 1'b1);
        repeat (15) step(1'b1, 1'b0, 1'b1);

        // Randomized run/stop, clear and ready.
        for (int i = 0; i < 2000; i++) begin
            bit rs, cl, rd;
            rs = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 49) == 0);
            rd = 1'($urandom_range(0, 1));
            step(rs, cl, rd);
        end

        // Reset while a value is still pending.
        for (int i = 0; i < 50 && !m_valid; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        do_reset();
        repeat (12) step(1'b1, 1'b0, 1'b1);

        chk("transfers_seen", 32'(n_xfer > 0), 1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
